softmax_stream: RTL and testbench
=================================

# softmax_stream

Parametrised fixed-point streaming softmax engine; successor to the single-width floating-point `softmax` block. It accepts a vector of up to `NMAX` signed fixed-point scores and buffers them internally while tracking the maximum. It computes max-subtracted exponentials, then streams normalised probabilities out under a ready/valid handshake. It sits between the classifier accumulator and the result FIFO.

## Interface
- `DATALENGTH`, 16, width of input scores and output probabilities.
- `FRAC`, 8, number of fractional bits. Input format is signed Q(DATALENGTH-FRAC).FRAC; output is unsigned Q.FRAC with 1.0 = `1<<FRAC`.
- `NMAX`, 32, buffer depth, i.e. the maximum vector length.
- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  begin a vector; sampled only in IDLE.
- `N`  in  clog2(NMAX+1)  vector length, latched on the accepted `Start`.
- `Datain`  in  DATALENGTH  signed score.
- `DatainValid`  in  1  `Datain` is valid this cycle.
- `Dataout`  out  DATALENGTH  probability; zero-extended above bit `FRAC`.
- `DataoutValid`  out  1  `Dataout` is valid.
- `DataoutReady`  in  1  downstream accepts `Dataout`.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse at the end of a vector.

## Operation
- States are IDLE, INPUTSTREAM, OP and OUTPUTSTREAM.
- **IDLE:** `Start`=1 latches `N`.
  - `N`>`NMAX` is clamped to `NMAX`.
  - `N`=0 pulses `Done` on the next cycle and stays in IDLE.
  - Otherwise go to INPUTSTREAM. `Start` in any other state is ignored.
- **INPUTSTREAM:**
  - Each cycle with `DatainValid`=1 writes `Datain` to buffer[i].
  - Max tracking: the first element initialises max; later elements update it with a signed compare.
  - After N writes, go to OP. `DatainValid`=0 stalls with no state change.
- **OP:** one element per cycle.
  - d = buffer[i] - max, which is always ≤ 0.
  - Split d into k = floor(d) and f = frac(d) in [0,1).
  - e = (`1<<FRAC` + f) >> (-k). If -k > `FRAC`, e = 0.
  - Write e back to buffer[i] and add it to sum. Sum width is `FRAC`+1+clog2(`NMAX`); it cannot overflow.
  - After N elements, go to OUTPUTSTREAM.
- **OUTPUTSTREAM:** for each i:
  - Restoring divider computes q = (e_i << `FRAC`) / sum over `FRAC`+1 iterations. The result is truncated; q ≤ `1<<FRAC`.
  - Then `Dataout`=q and `DataoutValid`=1.
  - Transfer happens when `DataoutValid` and `DataoutReady` are both 1. `Dataout` and `DataoutValid` hold stable until transfer.
  - After the Nth transfer: `Done`=1 for one cycle and return to IDLE.
- The max element always yields e = `1<<FRAC`, so sum ≥ `1<<FRAC` and division by zero is impossible.

## Timing
- **Reset (async, `Reset`=0):** state → IDLE. `Dataout`=0, `DataoutValid`=0, `Busy`=0, `Done`=0. Counters, max and sum are cleared.
  - This applies in any state, including mid-vector.
  - Buffer contents are don't-care.
- `Busy` rises the cycle after the accepted `Start`.
- INPUTSTREAM lasts N cycles at full rate. OP lasts exactly N cycles.
- Output latency per element is `FRAC`+2 cycles from the start of its divide to `DataoutValid` (10 cycles at `FRAC`=8).
  - The next divide starts the cycle after the transfer.
- `Done` is asserted in the cycle after the last transfer. `Busy` falls in the same cycle.
- The same-cycle transfer and last-element case is handled as described above; no extra bubble.

## Configuration
- Macro: `SOFTMAX_LOG2E_EN`.
- **Defined:** before the split, d is multiplied by log2(e) in Q.FRAC (0x171 at `FRAC`=8). The product is arithmetic-shifted right by `FRAC` and saturated at -(`FRAC`+1). The result is the natural softmax; OP takes one extra pipeline cycle (N+1 cycles total).
- **Undefined:** no multiplier; the result is the base-2 softmax (2^d normalised).

## Test plan
- Macro off, `FRAC`=8, N=2, inputs 0x0100, 0x0100 → outputs 0x0080, 0x0080, then `Done` pulse.
- Macro off, N=3, inputs 0x0200, 0x0100, 0x0000 → sum 0x1C0; outputs 0x0092, 0x0049, 0x0024.
- Macro on, N=2, inputs 0x0100, 0x0000 → e values 0x100 and 0x063; outputs 0x00B8, 0x0047.
- N=1 gives output 0x0100. N=0 gives a `Done` pulse with no `DataoutValid`. Inputs 0x0000, 0xEC00 (-20.0) → outputs 0x0100, 0x0000.
- Hold `DataoutReady`=0 for 5 cycles on the second output → `Dataout` stable and `DataoutValid` high throughout; the third element transfers correctly after release.
- Assert `Reset` low after 2 of N=4 inputs:
  - All outputs go to 0 and the state to IDLE immediately.
  - A following `Start` with N=2, inputs 0x0100, 0x0100 → 0x0080, 0x0080.

Source files
------------

// File: rtl/softmax_stream.sv
`timescale 1ns/1ps
// softmax_stream: buffered fixed-point streaming softmax with a ready/valid output.
// Scores are buffered while the maximum is tracked, replaced in place by
// max-subtracted base-2 exponentials, then normalised by a restoring divider.
// Optional macro SOFTMAX_LOG2E_EN scales the exponent argument by log2(e), which
// turns the result into the natural softmax. It adds one pipeline cycle to OP.
module softmax_stream #(
    parameter int DATALENGTH = 16,
    parameter int FRAC       = 8,
    parameter int NMAX       = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [$clog2(NMAX+1)-1:0] N,
    input  logic [DATALENGTH-1:0]     Datain,
    input  logic                      DatainValid,
    output logic [DATALENGTH-1:0]     Dataout,
    output logic                      DataoutValid,
    input  logic                      DataoutReady,
    output logic                      Busy,
    output logic                      Done
);
    localparam int CNT_W  = $clog2(NMAX + 1);
    localparam int IDX_W  = $clog2(NMAX);
    localparam int SUM_W  = FRAC + 1 + $clog2(NMAX);
    localparam int DCNT_W = $clog2(FRAC + 2);
    localparam logic [DATALENGTH:0] SH_MAX = (DATALENGTH+1)'(FRAC);

    typedef enum logic [1:0] {IDLE, INPUTSTREAM, OP, OUTPUTSTREAM} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             n_q, n_d, cnt_q, cnt_d, oidx_q, oidx_d;
    logic [CNT_W-1:0]             n_clamp, op_last;
    logic signed [DATALENGTH-1:0] max_q, max_d;
    logic [SUM_W-1:0]             sum_q, sum_d, rem_q, rem_d;
    logic [SUM_W:0]               rem_sh;
    logic [DCNT_W-1:0]            dcnt_q, dcnt_d;
    logic [FRAC:0]                dsr_q, dsr_d, quo_q, quo_d;
    logic [DATALENGTH-1:0]        dout_q, dout_d;
    logic                         dvld_q, dvld_d, done_q, done_d;

    logic [DATALENGTH-1:0]        buf_q [NMAX];
    logic [IDX_W-1:0]             rd_idx, wr_idx, e_idx;
    logic [DATALENGTH-1:0]        rd_data, wr_data;
    logic                         wr_en, e_vld;
    logic signed [DATALENGTH:0]   d_w, e_src;
    logic [FRAC:0]                e_val;

    // 2^d for d <= 0: mantissa (1 + frac) shifted right by -floor(d); underflows to zero
    function automatic logic [FRAC:0] exp2_neg(input logic signed [DATALENGTH:0] d);
        logic signed [DATALENGTH:0] k;
        logic [DATALENGTH:0]        nk;
        k  = d >>> FRAC;
        nk = -k;
        if (nk > SH_MAX) return '0;
        return {1'b1, d[FRAC-1:0]} >> nk;
    endfunction

    assign n_clamp = (N > CNT_W'(NMAX)) ? CNT_W'(NMAX) : N;
    assign rd_idx  = (state_q == OUTPUTSTREAM) ? oidx_q[IDX_W-1:0] : cnt_q[IDX_W-1:0];
    assign rd_data = buf_q[rd_idx];
    assign d_w     = $signed({rd_data[DATALENGTH-1], rd_data}) - $signed({max_q[DATALENGTH-1], max_q});
    assign e_val   = exp2_neg(e_src);

`ifdef SOFTMAX_LOG2E_EN
    localparam int LOG2E_I = int'(1.4426950408889634 * real'(1 << FRAC));
    localparam int SAT_I   = -((FRAC + 1) << FRAC);

    logic signed [DATALENGTH:0] sd_p1;
    logic [IDX_W-1:0]           idx_p1;
    logic                       vld_p1;

    // d * log2(e) back in Q.FRAC, clamped where the exponential is already zero
    function automatic logic signed [DATALENGTH:0] scale_log2e(input logic signed [DATALENGTH:0] d);
        int p;
        p = (int'(d) * LOG2E_I) >>> FRAC;
        if (p < SAT_I) p = SAT_I;
        return p[DATALENGTH:0];
    endfunction

    // Stage p1 data: scaled exponent argument and the buffer slot it belongs to
    always_ff @(posedge Clock) begin
        sd_p1  <= scale_log2e(d_w);
        idx_p1 <= rd_idx;
    end

    // Stage p1 valid: one token per element read during OP
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) vld_p1 <= 1'b0;
        else        vld_p1 <= (state_q == OP) && (cnt_q < n_q);
    end

    assign e_src   = sd_p1;
    assign e_idx   = idx_p1;
    assign e_vld   = vld_p1;
    assign op_last = n_q;
`else
    assign e_src   = d_w;
    assign e_idx   = rd_idx;
    assign e_vld   = (state_q == OP);
    assign op_last = n_q - CNT_W'(1);
`endif

    // Score/exponential buffer; contents need no reset
    always_ff @(posedge Clock) begin
        if (wr_en) buf_q[wr_idx] <= wr_data;
    end

    // Next-state logic for the sequencer, max/sum tracking and the divider
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        oidx_d  = oidx_q;
        max_d   = max_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        dcnt_d  = dcnt_q;
        dout_d  = dout_q;
        dvld_d  = dvld_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = e_idx;
        wr_data = DATALENGTH'(e_val);
        rem_sh  = '0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (n_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d     = n_clamp;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = INPUTSTREAM;
                    end
                end
            end
            INPUTSTREAM: begin
                if (DatainValid) begin
                    wr_en   = 1'b1;
                    wr_idx  = cnt_q[IDX_W-1:0];
                    wr_data = Datain;
                    if (cnt_q == '0 || $signed(Datain) > max_q) max_d = $signed(Datain);
                    if (cnt_q == n_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = OP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (e_vld) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + SUM_W'(e_val);
                end
                if (cnt_q == op_last) begin
                    cnt_d   = '0;
                    oidx_d  = '0;
                    dcnt_d  = '0;
                    dvld_d  = 1'b0;
                    state_d = OUTPUTSTREAM;
                end
            end
            OUTPUTSTREAM: begin
                if (dvld_q) begin
                    if (DataoutReady) begin
                        dvld_d = 1'b0;
                        if (oidx_q == n_q - CNT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            oidx_d = oidx_q + CNT_W'(1);
                            dcnt_d = '0;
                        end
                    end
                end else if (dcnt_q == '0) begin
                    // Dividend is e << FRAC; its bits above FRAC+1 (e >> 1) are already below sum
                    rem_d  = SUM_W'(rd_data[FRAC:1]);
                    dsr_d  = {rd_data[0], {FRAC{1'b0}}};
                    quo_d  = '0;
                    dcnt_d = DCNT_W'(1);
                end else begin
                    rem_sh = {rem_q, dsr_q[FRAC]};
                    if (rem_sh >= {1'b0, sum_q}) begin
                        rem_d = rem_sh[SUM_W-1:0] - sum_q;
                        quo_d = {quo_q[FRAC-1:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[SUM_W-1:0];
                        quo_d = {quo_q[FRAC-1:0], 1'b0};
                    end
                    dsr_d  = {dsr_q[FRAC-1:0], 1'b0};
                    dcnt_d = dcnt_q + DCNT_W'(1);
                    if (dcnt_q == DCNT_W'(FRAC + 1)) begin
                        dout_d = DATALENGTH'(quo_d);
                        dvld_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            oidx_q  <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            dcnt_q  <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            oidx_q  <= oidx_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            dcnt_q  <= dcnt_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            done_q  <= done_d;
        end
    end

    assign Dataout      = dout_q;
    assign DataoutValid = dvld_q;
    assign Busy         = (state_q != IDLE);
    assign Done         = done_q;

endmodule

// File: tb/tb_softmax_stream.sv
`timescale 1ns/1ps
// Testbench for softmax_stream: directed vectors, behavioural softmax model,
// cycle-by-cycle output checker and hand-computed literal expectations.
module tb_softmax_stream;
    localparam int DL = 16;
    localparam int FR = 8;
    localparam int NM = 32;
    localparam int CW = $clog2(NM + 1);

    typedef logic [DL-1:0] vec_t[$];

    logic          Clock = 1'b0;
    logic          Reset, Start, DatainValid, DataoutReady;
    logic          DataoutValid, Busy, Done;
    logic [CW-1:0] N;
    logic [DL-1:0] Datain, Dataout;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int got_q[$];
    bit allow_done = 1'b0;
    bit done_due   = 1'b0;
    bit hold_prev  = 1'b0;
    logic [DL-1:0] prev_dout = '0;

    always #5 Clock = ~Clock;

    softmax_stream #(.DATALENGTH(DL), .FRAC(FR), .NMAX(NM)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .N           (N),
        .Datain      (Datain),
        .DatainValid (DatainValid),
        .Dataout     (Dataout),
        .DataoutValid(DataoutValid),
        .DataoutReady(DataoutReady),
        .Busy        (Busy),
        .Done        (Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Softmax as the arithmetic rules define it: exponent of (x - max), normalise, truncate
    function automatic void softmax_model(input int xs[$], output int qs[$]);
        int mx, sum;
        int es[$];
        mx = xs[0];
        foreach (xs[i]) if (xs[i] > mx) mx = xs[i];
        sum = 0;
        foreach (xs[i]) begin
            int d, k, f, e;
            d = xs[i] - mx;
`ifdef SOFTMAX_LOG2E_EN
            d = int'($floor(real'(d) * 369.0 / 256.0));
            if (d < -(FR + 1) * 256) d = -(FR + 1) * 256;
`endif
            k = int'($floor(real'(d) / 256.0));
            f = d - k * 256;
            e = (-k > FR) ? 0 : ((256 + f) >> (-k));
            es.push_back(e);
            sum += e;
        end
        qs = {};
        foreach (es[i]) qs.push_back((es[i] * 256) / sum);
    endfunction

    // Output checker: values on every transfer, hold while stalled, Done timing
    always @(negedge Clock) begin
        bit due;
        int e;
        if (!Reset) begin
            done_due  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            due      = done_due;
            done_due = 1'b0;
            if (due) begin
                check("done_after_last", Done, 1);
                check("busy_fall", Busy, 0);
            end else if (Done && !allow_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: Done=1, required 0");
            end
            if (hold_prev) begin
                check("hold_valid", DataoutValid, 1);
                check("hold_data", Dataout, prev_dout);
            end
            if (DataoutValid) check("busy_during_out", Busy, 1);
            if (DataoutValid && DataoutReady) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: Dataout=0x%0h with no element pending", Dataout);
                end else begin
                    e = exp_q.pop_front();
                    check("dataout", Dataout, e);
                    got_q.push_back(int'(Dataout));
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
            hold_prev = DataoutValid && !DataoutReady;
            prev_dout = Dataout;
        end
    end

    task automatic run_vector(input int n, input vec_t xs, input int stall_at);
        int xi[$];
        int q[$];
        int c;
        foreach (xs[i]) xi.push_back(int'($signed(xs[i])));
        if (xi.size() > 0) softmax_model(xi, q);
        exp_q = q;
        got_q.delete();
        allow_done = (n == 0);
        @(posedge Clock); #1;
        Start = 1'b1;
        N     = CW'(n);
        @(posedge Clock); #1;
        Start = 1'b0;
        check("busy_rise", Busy, (n > 0));
        if (n == 0) begin
            check("zero_done", Done, 1);
            @(posedge Clock); #1;
            check("zero_done_pulse", Done, 0);
            check("zero_no_valid", DataoutValid, 0);
            allow_done = 1'b0;
            return;
        end
        foreach (xs[i]) begin
            Datain      = xs[i];
            DatainValid = 1'b1;
            @(posedge Clock); #1;
            if (i == 0 && xs.size() > 1) begin
                DatainValid = 1'b0;
                @(posedge Clock); #1;
            end
        end
        DatainValid = 1'b0;
        if (stall_at >= 0) begin
            for (c = 0; c < 500 && got_q.size() < stall_at; c++) @(posedge Clock);
            #1 DataoutReady = 1'b0;
            for (c = 0; c < 500 && !DataoutValid; c++) @(negedge Clock);
            repeat (5) @(negedge Clock);
            @(posedge Clock); #1 DataoutReady = 1'b1;
        end
        for (c = 0; c < 3000 && !Done; c++) @(negedge Clock);
        check("done_seen", Done, 1);
        @(negedge Clock);
        check("done_pulse", Done, 0);
        check("out_count", got_q.size(), xs.size());
    endtask

    task automatic check_lits(input string name, input int lits[$]);
        foreach (lits[i]) check(name, (i < got_q.size()) ? got_q[i] : -1, lits[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        Reset = 1'b1; Start = 1'b0; N = '0; Datain = '0;
        DatainValid = 1'b0; DataoutReady = 1'b1;

        #3 Reset = 1'b0;
        #1;
        check("rst_dout", Dataout, 0);
        check("rst_valid", DataoutValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;

        v = {16'h0100, 16'h0100};
        run_vector(2, v, -1);
        check_lits("equal_pair", {32'h80, 32'h80});

        v = {16'h0200, 16'h0100, 16'h0000};
        run_vector(3, v, -1);
`ifndef SOFTMAX_LOG2E_EN
        check_lits("three_step", {32'h92, 32'h49, 32'h24});
`endif

        v = {16'h0100, 16'h0000};
        run_vector(2, v, -1);
`ifdef SOFTMAX_LOG2E_EN
        check_lits("natural_pair", {32'hB8, 32'h47});
`else
        check_lits("base2_pair", {32'hAA, 32'h55});
`endif

        v = {16'h1234};
        run_vector(1, v, -1);
        check_lits("single", {32'h100});

        v = {};
        run_vector(0, v, -1);

        v = {16'h0000, 16'hEC00};
        run_vector(2, v, -1);
        check_lits("underflow", {32'h100, 32'h0});

        v = {};
        for (int i = 0; i < NM; i++) v.push_back(16'(i * 53 - 700));
        run_vector(40, v, -1);

        v = {16'h0100, 16'h0300, 16'h0200};
        run_vector(3, v, 1);
`ifndef SOFTMAX_LOG2E_EN
        check_lits("stalled", {32'h24, 32'h92, 32'h49});
`endif

        // Reset in the middle of a 4-element input phase
        exp_q.delete();
        @(posedge Clock); #1;
        Start = 1'b1;
        N     = CW'(4);
        @(posedge Clock); #1;
        Start       = 1'b0;
        Datain      = 16'h0100;
        DatainValid = 1'b1;
        @(posedge Clock); #1;
        Datain = 16'h0200;
        @(posedge Clock); #1;
        DatainValid = 1'b0;
        check("pre_reset_busy", Busy, 1);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_dout", Dataout, 0);
        check("mid_rst_valid", DataoutValid, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        exp_q.delete();
        got_q.delete();
        @(posedge Clock); #1;
        check("rst_hold_idle", Busy, 0);
        Reset = 1'b1;

        v = {16'h0100, 16'h0100};
        run_vector(2, v, -1);
        check_lits("after_reset", {32'h80, 32'h80});

        repeat (3) @(posedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
